// File: rtl/nios2_spi_sequencer.sv
// Command engine that drives the nios2_spi register port to run multi-byte SPI
// transfers between a TX byte stream and an RX byte stream.
module nios2_spi_sequencer #(
  parameter int NUMSLAVES  = 4,
  parameter int POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_slave,
  input  logic [7:0]  cmd_len,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        spi_select,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [2:0]  spi_mem_addr,
  output logic [15:0] spi_data_from_cpu,
  input  logic [15:0] spi_data_to_cpu
);

  typedef enum logic [3:0] {
    IDLE, SEL, SSO_ON, WAIT_TX, WR_TX, POLL_R, RD_RX,
    PUSH_RX, POLL_TMT, SSO_OFF, CLR, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [1:0]  slave_q, slave_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  txb_q, txb_d;
  logic [8:0]  rdata_q, rdata_d;
  logic [15:0] poll_q, poll_d;
  logic        err_q, err_d;
  logic [7:0]  rxd_q, rxd_d;

  logic        cmd_ready_q, tx_ready_q, rx_valid_q, done_q;
  logic        sel_q, rdn_q, wrn_q, sel_d, rdn_d, wrn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;

  logic [NUMSLAVES-1:0] sel_mask;
  logic        is_bus, is_rd, poll_hit, poll_exp;
  logic        unused_bits;

  assign unused_bits = ^spi_data_to_cpu[15:9];

  function automatic logic bus_state(input state_e s);
    return (s == SEL) || (s == SSO_ON) || (s == WR_TX) || (s == POLL_R) ||
           (s == RD_RX) || (s == POLL_TMT) || (s == SSO_OFF) || (s == CLR);
  endfunction

  assign is_bus   = bus_state(state_q);
  assign is_rd    = (state_q == POLL_R) || (state_q == RD_RX) || (state_q == POLL_TMT);
  assign poll_hit = (state_q == POLL_R) ? rdata_q[7] : rdata_q[5];
  assign poll_exp = ({1'b0, poll_q} + 17'd1) >= 17'(POLL_LIMIT);

  // Every access runs A1/A2/A3 on ph 0/1/2; decisions are taken at the end of A3.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    slave_d = slave_q;
    rem_d   = rem_q;
    txb_d   = txb_q;
    rdata_d = rdata_q;
    poll_d  = poll_q;
    err_d   = err_q;
    rxd_d   = rxd_q;
    if (is_bus && is_rd && ph_q == 2'd1) rdata_d = spi_data_to_cpu[8:0];
    if (is_bus && ph_q != 2'd2) ph_d = ph_q + 2'd1;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SEL;
        ph_d    = 2'd0;
        slave_d = cmd_slave;
        rem_d   = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
        err_d   = 1'b0;
      end
      SEL:    if (ph_q == 2'd2) begin state_d = SSO_ON;  ph_d = 2'd0; end
      SSO_ON: if (ph_q == 2'd2) begin state_d = WAIT_TX; ph_d = 2'd0; end
      WAIT_TX: if (tx_valid) begin
        state_d = WR_TX;
        ph_d    = 2'd0;
        txb_d   = tx_data;
      end
      WR_TX: if (ph_q == 2'd2) begin
        state_d = POLL_R;
        ph_d    = 2'd0;
        poll_d  = 16'd0;
      end
      POLL_R, POLL_TMT: if (ph_q == 2'd2) begin
        ph_d = 2'd0;
        if (rdata_q[8]) err_d = 1'b1;
        if (poll_hit) begin
          state_d = (state_q == POLL_R) ? RD_RX : SSO_OFF;
        end else if (poll_exp) begin
          err_d   = 1'b1;
          state_d = SSO_OFF;
        end else begin
          poll_d = poll_q + 16'd1;
        end
      end
      RD_RX: if (ph_q == 2'd2) begin
        state_d = PUSH_RX;
        ph_d    = 2'd0;
        rxd_d   = rdata_q[7:0];
      end
      PUSH_RX: if (rx_ready) begin
        rem_d  = rem_q - 9'd1;
        ph_d   = 2'd0;
        poll_d = 16'd0;
        state_d = (rem_q == 9'd1) ? POLL_TMT : WAIT_TX;
      end
      SSO_OFF: if (ph_q == 2'd2) begin state_d = err_q ? CLR : DONE; ph_d = 2'd0; end
      CLR:     if (ph_q == 2'd2) begin state_d = DONE; ph_d = 2'd0; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are a registered function of the next state, so A1 appears
  // on the very cycle the state is entered.
  always_comb begin
    sel_mask = {{(NUMSLAVES-1){1'b0}}, 1'b1} << slave_d;
    sel_d  = 1'b0;
    rdn_d  = 1'b1;
    wrn_d  = 1'b1;
    addr_d = 3'd0;
    wdat_d = 16'h0000;
    if (bus_state(state_d) && ph_d != 2'd2) begin
      sel_d = 1'b1;
      unique case (state_d)
        SEL:      begin addr_d = 3'd5; wdat_d = 16'(sel_mask); wrn_d = 1'b0; end
        SSO_ON:   begin addr_d = 3'd3; wdat_d = 16'h0400;      wrn_d = 1'b0; end
        WR_TX:    begin addr_d = 3'd1; wdat_d = {8'h00, txb_d}; wrn_d = 1'b0; end
        POLL_R,
        POLL_TMT: begin addr_d = 3'd2; rdn_d = 1'b0; end
        RD_RX:    begin addr_d = 3'd0; rdn_d = 1'b0; end
        SSO_OFF:  begin addr_d = 3'd3; wrn_d = 1'b0; end
        CLR:      begin addr_d = 3'd2; wrn_d = 1'b0; end
        default:  sel_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      slave_q     <= 2'd0;
      rem_q       <= 9'd0;
      txb_q       <= 8'h00;
      rdata_q     <= 9'd0;
      poll_q      <= 16'd0;
      err_q       <= 1'b0;
      rxd_q       <= 8'h00;
      cmd_ready_q <= 1'b1;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      sel_q       <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      addr_q      <= 3'd0;
      wdat_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      slave_q     <= slave_d;
      rem_q       <= rem_d;
      txb_q       <= txb_d;
      rdata_q     <= rdata_d;
      poll_q      <= poll_d;
      err_q       <= err_d;
      rxd_q       <= rxd_d;
      cmd_ready_q <= (state_d == IDLE);
      tx_ready_q  <= (state_d == WAIT_TX);
      rx_valid_q  <= (state_d == PUSH_RX);
      done_q      <= (state_d == DONE);
      sel_q       <= sel_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign busy              = ~cmd_ready_q;
  assign tx_ready          = tx_ready_q;
  assign rx_valid          = rx_valid_q;
  assign rx_data           = rxd_q;
  assign done              = done_q;
  assign err               = err_q;
  assign spi_select        = sel_q;
  assign spi_read_n        = rdn_q;
  assign spi_write_n       = wrn_q;
  assign spi_mem_addr      = addr_q;
  assign spi_data_from_cpu = wdat_q;

endmodule

// File: tb/tb_nios2_spi_sequencer.sv
// Directed bench for nios2_spi_sequencer with a small behavioural model of the
// nios2_spi register port (status/rxdata, byte latency, ROE, injected E bit).
module tb_nios2_spi_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [1:0]  cmd_slave;
  logic [7:0]  cmd_len, tx_data, rx_data;
  logic        done, err, busy, spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu, spi_data_to_cpu;

  always #5 clk = ~clk;

  nios2_spi_sequencer #(.NUMSLAVES(4), .POLL_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave), .cmd_len(cmd_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .err(err), .busy(busy),
    .spi_select(spi_select), .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
    .spi_mem_addr(spi_mem_addr), .spi_data_from_cpu(spi_data_from_cpu),
    .spi_data_to_cpu(spi_data_to_cpu)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [19:0] acc(input bit w, input bit [2:0] a, input bit [15:0] d);
    return {w, a, d};
  endfunction

  // stimulus-side knobs
  logic [7:0] tx_mem [256];
  logic       miso_const, never_rrdy, e_inject;

  // core model state
  bit [19:0]  acc_q[$];
  logic [7:0] rxq[$];
  int         acc_cyc, busy_c, tx_idx, done_cnt, bad_len, bad_strb;
  bit         tx_pend, rrdy, tmt, e_fl, e_used, roe, err_at_done;
  logic [7:0] rxbuf, pend;

  assign tx_data = tx_mem[tx_idx[7:0]];
  assign spi_data_to_cpu = (spi_mem_addr == 3'd2) ? {7'b0, e_fl, rrdy, 1'b0, tmt, 5'b0} :
                           (spi_mem_addr == 3'd0) ? {8'h00, rxbuf} : 16'h0000;

  always @(negedge clk) begin
    if (!reset_n) begin
      acc_q.delete(); rxq.delete();
      acc_cyc = 0; busy_c = 0; tx_idx = 0; done_cnt = 0; bad_len = 0; bad_strb = 0;
      tx_pend = 0; rrdy = 0; tmt = 1; e_fl = 0; e_used = 0; roe = 0; err_at_done = 0;
      rxbuf = 8'h00; pend = 8'h00;
    end else begin
      if (tx_pend) begin tx_idx++; tx_pend = 0; end
      if (tx_valid && tx_ready) tx_pend = 1;
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (done) begin done_cnt++; err_at_done = err; end
      if (spi_select) begin
        acc_cyc++;
        if (spi_read_n == spi_write_n) bad_strb++;
        if (acc_cyc == 1) begin
          acc_q.push_back(acc(~spi_write_n, spi_mem_addr, spi_write_n ? 16'h0 : spi_data_from_cpu));
          if (!spi_write_n && spi_mem_addr == 3'd1) begin
            pend   = miso_const ? 8'h3C : spi_data_from_cpu[7:0];
            busy_c = 6;
            tmt    = 0;
          end
          if (!spi_read_n && spi_mem_addr == 3'd2 && e_inject && !e_used) begin
            e_fl = 1; e_used = 1;
          end
        end
        if (acc_cyc == 2 && !spi_read_n && spi_mem_addr == 3'd0) rrdy = 0;
      end else begin
        if (acc_cyc != 0 && acc_cyc != 2) bad_len++;
        if (acc_cyc != 0) e_fl = 0;
        acc_cyc = 0;
      end
      if (busy_c > 0) begin
        busy_c--;
        if (busy_c == 0 && !never_rrdy) begin
          if (rrdy) roe = 1;
          rxbuf = pend; rrdy = 1; tmt = 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic start_cmd(input logic [1:0] s, input logic [7:0] len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_slave = s; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("accept_ready_drop", cmd_ready, 1'b0);
    chk("accept_sel_a1", {spi_select, spi_write_n, spi_mem_addr}, {1'b1, 1'b0, 3'd5});
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin @(negedge clk); n++; end
    chk("done_in_time", done_cnt != 0, 1'b1);
    repeat (6) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("acc_len", bad_len, 0);
    chk("acc_strobe", bad_strb, 0);
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, busy, done, err, tx_ready, rx_valid}, 6'b100000);
    chk({tag, "_rxd"}, rx_data, 8'h00);
    chk({tag, "_bus"}, {spi_select, spi_read_n, spi_write_n, spi_mem_addr}, {3'b011, 3'd0});
    chk({tag, "_wdat"}, spi_data_from_cpu, 16'h0000);
  endtask

  initial begin
    int n, wr_cnt, rd2_cnt, bad_rx, stall_bad;
    logic [7:0] held;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_slave = 2'd0; cmd_len = 8'd0;
    tx_valid = 1'b0; rx_ready = 1'b1;
    miso_const = 1'b0; never_rrdy = 1'b0; e_inject = 1'b0;
    for (int i = 0; i < 256; i++) tx_mem[i] = i[7:0];
    repeat (3) @(posedge clk);
    #1 chk_outputs_reset("reset");
    reset_n = 1'b1;

    // single byte to slave 2, core returns 0x3C
    tx_mem[0] = 8'hA5; miso_const = 1'b1; tx_valid = 1'b1;
    start_cmd(2'd2, 8'd1);
    wait_done(400);
    chk("s1_n_acc_min", acc_q.size() >= 7, 1'b1);
    chk("s1_sel", acc_q[0], acc(1, 5, 16'h0004));
    chk("s1_sso_on", acc_q[1], acc(1, 3, 16'h0400));
    chk("s1_txdata", acc_q[2], acc(1, 1, 16'h00A5));
    chk("s1_first_poll", acc_q[3], acc(0, 2, 16'h0));
    chk("s1_sso_off", acc_q[acc_q.size()-1], acc(1, 3, 16'h0000));
    chk("s1_rx_cnt", rxq.size(), 1);
    chk("s1_rx", rxq[0], 8'h3C);
    chk("s1_err", err_at_done, 1'b0);

    // 256-byte loopback
    do_reset();
    miso_const = 1'b0;
    for (int i = 0; i < 256; i++) tx_mem[i] = i[7:0];
    start_cmd(2'd0, 8'd0);
    wait_done(20000);
    wr_cnt = 0; bad_rx = 0;
    foreach (acc_q[i]) if (acc_q[i][19:16] == 4'b1001) wr_cnt++;
    foreach (rxq[i]) if (rxq[i] !== 8'(i)) bad_rx++;
    chk("l256_wr_tx", wr_cnt, 256);
    chk("l256_rx_cnt", rxq.size(), 256);
    chk("l256_rx_order", bad_rx, 0);
    chk("l256_err", err_at_done, 1'b0);

    // rx backpressure on the second of three bytes
    do_reset();
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33;
    start_cmd(2'd1, 8'd3);
    n = 0;
    while (rxq.size() < 1 && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1 rx_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rx_valid && n < 500) begin @(negedge clk); n++; end
    chk("bp_rx_valid", rx_valid, 1'b1);
    held = rx_data; stall_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rx_valid || rx_data !== held || spi_select || tx_ready) stall_bad++;
    end
    chk("bp_stall_stable", stall_bad, 0);
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_done(600);
    chk("bp_rx_cnt", rxq.size(), 3);
    chk("bp_rx_seq", {rxq[0], rxq[1], rxq[2]}, 24'h112233);
    chk("bp_roe", roe, 1'b0);

    // status poll timeout
    do_reset();
    never_rrdy = 1'b1; tx_mem[0] = 8'h55;
    start_cmd(2'd3, 8'd1);
    wait_done(400);
    rd2_cnt = 0;
    foreach (acc_q[i]) if (acc_q[i][19:16] == 4'b0010) rd2_cnt++;
    chk("to_polls", rd2_cnt, 4);
    chk("to_n_acc", acc_q.size(), 9);
    chk("to_sso_off", acc_q[7], acc(1, 3, 16'h0000));
    chk("to_clr", acc_q[8], acc(1, 2, 16'h0000));
    chk("to_err", err_at_done, 1'b1);
    chk("to_no_rx", rxq.size(), 0);
    never_rrdy = 1'b0;

    // E bit on one status read
    do_reset();
    e_inject = 1'b1; tx_mem[0] = 8'h5A;
    start_cmd(2'd0, 8'd1);
    wait_done(400);
    chk("e_rx", {rxq.size() == 1, rxq[0]}, {1'b1, 8'h5A});
    chk("e_sso_off", acc_q[acc_q.size()-2], acc(1, 3, 16'h0000));
    chk("e_clr", acc_q[acc_q.size()-1], acc(1, 2, 16'h0000));
    chk("e_err", err_at_done, 1'b1);
    chk("e_err_held", err, 1'b1);
    e_inject = 1'b0;

    // reset while polling RRDY, then a clean command
    tx_mem[0] = 8'h77;
    start_cmd(2'd1, 8'd1);
    chk("e_err_cleared", err, 1'b0);
    n = 0;
    while (!(spi_select && !spi_read_n && spi_mem_addr == 3'd2) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("rst_in_poll", spi_mem_addr, 3'd2);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 chk_outputs_reset("rst_mid");
    reset_n = 1'b1;
    start_cmd(2'd2, 8'd1);
    wait_done(400);
    chk("rst_sel", acc_q[0], acc(1, 5, 16'h0004));
    chk("rst_rx", {rxq.size() == 1, rxq[0]}, {1'b1, 8'h77});
    chk("rst_err", err_at_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
